// File: rtl/fdsyncr_bank.sv
// -----------------------------------------------------------------------------
// fdsyncr_bank
//   Bank of CHANNELS double-buffered WIDTH-bit registers. Software writes the
//   shadow stage at any time. A global commit strobe copies every pending
//   shadow into its active stage in a single edge, so a group of timing
//   registers changes atomically at a frame or line boundary.
//
// Optional feature macro: FDSYNCR_QN_EN
//   When defined, adds output qn. qn is the registered bitwise complement of q.
//
// Ports
//   sys_clk    in   single system clock, rising edge
//   rst        in   synchronous, active-high reset
//   wr_en      in   shadow write strobe
//   wr_ch      in   [CW]        channel written (ignored if >= CHANNELS)
//   wr_data    in   [WIDTH]     shadow write data
//   commit     in   copy pending shadows to active
//   rd_ch      in   [CW]        shadow readback select
//   q          out  [CHANNELS*WIDTH] active values, channel n at [n*WIDTH +: WIDTH]
//   pend       out  [CHANNELS]  shadow holds uncommitted data
//   ovr        out  [CHANNELS]  sticky: rewritten while already pending
//   rd_shadow  out  [WIDTH]     combinational shadow of rd_ch (0 if out of range)
//   qn         out  [CHANNELS*WIDTH] ~q, registered (FDSYNCR_QN_EN only)
// -----------------------------------------------------------------------------
module fdsyncr_bank #(
    parameter int               WIDTH     = 6,
    parameter int               CHANNELS  = 4,
    parameter int               CW        = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                      sys_clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [CW-1:0]             wr_ch,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      commit,
    input  logic [CW-1:0]             rd_ch,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS-1:0]       pend,
    output logic [CHANNELS-1:0]       ovr,
    output logic [WIDTH-1:0]          rd_shadow
`ifdef FDSYNCR_QN_EN
    ,
    output logic [CHANNELS*WIDTH-1:0] qn
`endif
);

    // Per-channel status: IDLE (nothing pending), PEND (pending),
    // OVR (pending and overwritten before commit).
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_OVR  = 2'd2
    } ch_state_t;

    ch_state_t        r_state      [CHANNELS];
    ch_state_t        w_next_state [CHANNELS];
    logic [WIDTH-1:0] r_shadow     [CHANNELS];
    logic [WIDTH-1:0] r_active     [CHANNELS];
`ifdef FDSYNCR_QN_EN
    logic [WIDTH-1:0] r_active_n   [CHANNELS];
`endif
    logic [CHANNELS-1:0] w_wr_hit;
    logic [CHANNELS-1:0] w_commit_ch;

    // Channel decode. Comparing against in-range indices only means an
    // out-of-range wr_ch simply hits nothing.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            w_wr_hit[c] = wr_en && (int'(wr_ch) == c);
        end
    end

    // Next-state logic. A commit wins over the overrun transition: a write in
    // the commit cycle starts a fresh pending period rather than an overrun.
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            w_next_state[c] = r_state[c];
            w_commit_ch[c]  = 1'b0;
            unique case (r_state[c])
                ST_IDLE: begin
                    if (w_wr_hit[c]) w_next_state[c] = ST_PEND;
                end
                ST_PEND, ST_OVR: begin
                    if (commit) begin
                        w_commit_ch[c]  = 1'b1;
                        w_next_state[c] = w_wr_hit[c] ? ST_PEND : ST_IDLE;
                    end else if (w_wr_hit[c]) begin
                        w_next_state[c] = ST_OVR;
                    end
                end
                default: w_next_state[c] = ST_IDLE;
            endcase
        end
    end

    // NOTE: non-blocking assignments make the active copy take the shadow value
    // held before this edge, even when the shadow is rewritten in the same cycle.
    // NOTE: the shadow array is reset along with the rest because readback of
    // an unwritten channel must return RESET_VAL, not an undefined value.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_state[c]    <= ST_IDLE;
                r_shadow[c]   <= RESET_VAL;
                r_active[c]   <= RESET_VAL;
`ifdef FDSYNCR_QN_EN
                r_active_n[c] <= ~RESET_VAL;
`endif
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_state[c] <= w_next_state[c];
                if (w_wr_hit[c]) r_shadow[c] <= wr_data;
                if (w_commit_ch[c]) begin
                    r_active[c]   <= r_shadow[c];
`ifdef FDSYNCR_QN_EN
                    r_active_n[c] <= ~r_shadow[c];
`endif
                end
            end
        end
    end

    // Output packing and shadow readback mux.
    always_comb begin
        rd_shadow = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            q[c*WIDTH +: WIDTH] = r_active[c];
`ifdef FDSYNCR_QN_EN
            qn[c*WIDTH +: WIDTH] = r_active_n[c];
`endif
            pend[c] = (r_state[c] != ST_IDLE);
            ovr[c]  = (r_state[c] == ST_OVR);
            if (int'(rd_ch) == c) rd_shadow = r_shadow[c];
        end
    end

endmodule

// File: tb/tb_fdsyncr_bank.sv
// -----------------------------------------------------------------------------
// tb_fdsyncr_bank
//   Self-checking bench for fdsyncr_bank (WIDTH=6, CHANNELS=4, CW=3 so that
//   out-of-range channel indices can be driven). A behavioural model tracks
//   shadow/active/pend/ovr per channel; a negedge process compares every
//   output against it each cycle. Directed scenarios pin the model with
//   literal expectations, then a randomized phase runs.
// -----------------------------------------------------------------------------
module tb_fdsyncr_bank;

    localparam int W  = 6;
    localparam int N  = 4;
    localparam int CWB = 3;

    logic              sys_clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [CWB-1:0]    wr_ch;
    logic [W-1:0]      wr_data;
    logic              commit;
    logic [CWB-1:0]    rd_ch;
    logic [N*W-1:0]    q;
    logic [N-1:0]      pend;
    logic [N-1:0]      ovr;
    logic [W-1:0]      rd_shadow;
`ifdef FDSYNCR_QN_EN
    logic [N*W-1:0]    qn;
`endif

    fdsyncr_bank #(
        .WIDTH(W), .CHANNELS(N), .CW(CWB), .RESET_VAL('0)
    ) dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_ch     (wr_ch),
        .wr_data   (wr_data),
        .commit    (commit),
        .rd_ch     (rd_ch),
        .q         (q),
        .pend      (pend),
        .ovr       (ovr),
        .rd_shadow (rd_shadow)
`ifdef FDSYNCR_QN_EN
        ,
        .qn        (qn)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0] m_shadow [N];
    logic [W-1:0] m_active [N];
    logic         m_pend   [N];
    logic         m_ovr    [N];

    function automatic logic hits(input int c);
        return wr_en && (int'(wr_ch) == c);
    endfunction

    always @(posedge sys_clk) begin
        for (int c = 0; c < N; c++) begin
            if (rst) begin
                m_shadow[c] <= '0;
                m_active[c] <= '0;
                m_pend[c]   <= 1'b0;
                m_ovr[c]    <= 1'b0;
            end else begin
                if (commit && m_pend[c]) m_active[c] <= m_shadow[c];
                if (hits(c)) m_shadow[c] <= wr_data;
                m_pend[c] <= hits(c) ? 1'b1 : (commit ? 1'b0 : m_pend[c]);
                m_ovr[c]  <= (hits(c) && m_pend[c] && !commit) ? 1'b1
                           : (commit ? 1'b0 : m_ovr[c]);
            end
        end
    end

    function automatic logic [N*W-1:0] model_q();
        logic [N*W-1:0] v;
        for (int c = 0; c < N; c++) v[c*W +: W] = m_active[c];
        return v;
    endfunction

    function automatic logic [N-1:0] model_pend();
        logic [N-1:0] v;
        for (int c = 0; c < N; c++) v[c] = m_pend[c];
        return v;
    endfunction

    function automatic logic [N-1:0] model_ovr();
        logic [N-1:0] v;
        for (int c = 0; c < N; c++) v[c] = m_ovr[c];
        return v;
    endfunction

    function automatic logic [W-1:0] model_rd(input logic [CWB-1:0] ch);
        return (int'(ch) < N) ? m_shadow[int'(ch)] : '0;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge sys_clk) begin
        if (cmp_en) begin
            check("q", q, model_q());
            check("pend", pend, model_pend());
            check("ovr", ovr, model_ovr());
            check("rd_shadow", rd_shadow, model_rd(rd_ch));
`ifdef FDSYNCR_QN_EN
            check("qn", qn, ~model_q());
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; commit = 1'b0; rst = 1'b0;
    endtask

    task automatic write(input logic [CWB-1:0] ch, input logic [W-1:0] d, input logic cm);
        wr_en = 1'b1; wr_ch = ch; wr_data = d; commit = cm;
        tick();
        idle_inputs();
    endtask

    task automatic do_commit();
        commit = 1'b1;
        tick();
        idle_inputs();
    endtask

    initial begin
        // Reset held two cycles with write and commit also asserted.
        rst = 1'b1; wr_en = 1'b1; commit = 1'b1; wr_ch = 3'd2; wr_data = 6'h3F; rd_ch = '0;
        tick();
        tick();
        idle_inputs();
        cmp_en = 1'b1;
        check("reset_q", q, 24'h0);
        check("reset_pend", pend, 4'b0000);
        check("reset_ovr", ovr, 4'b0000);
        for (int c = 0; c < N; c++) begin
            rd_ch = 3'(c);
            #1;
            check("reset_rd_shadow", rd_shadow, 6'h00);
        end

        // Basic write then commit.
        write(3'd2, 6'h2A, 1'b0);
        rd_ch = 3'd2;
        #1;
        check("basic_q_hold", q[2*W +: W], 6'h00);
        check("basic_pend", pend, 4'b0100);
        check("basic_rd", rd_shadow, 6'h2A);
        do_commit();
        check("basic_q_commit", q[2*W +: W], 6'h2A);
        check("basic_pend_clr", pend, 4'b0000);

        // Overrun.
        write(3'd1, 6'h05, 1'b0);
        write(3'd1, 6'h09, 1'b0);
        check("ovr_set", ovr, 4'b0010);
        do_commit();
        check("ovr_q", q[1*W +: W], 6'h09);
        check("ovr_clr", ovr, 4'b0000);
        check("ovr_pend_clr", pend, 4'b0000);

        // Collision: write and commit on the same pending channel.
        write(3'd0, 6'h11, 1'b0);
        write(3'd0, 6'h22, 1'b1);
        check("coll_q", q[0 +: W], 6'h11);
        check("coll_pend", pend, 4'b0001);
        check("coll_ovr", ovr, 4'b0000);
        do_commit();
        check("coll_q2", q[0 +: W], 6'h22);

        // Out-of-range write and idle commit.
        write(3'd5, 6'h15, 1'b0);
        check("range_pend", pend, 4'b0000);
        check("range_q", q, {6'h00, 6'h2A, 6'h09, 6'h22});
        rd_ch = 3'd5;
        #1;
        check("range_rd", rd_shadow, 6'h00);
        do_commit();
        check("idle_commit_q", q, {6'h00, 6'h2A, 6'h09, 6'h22});

        // Reset in the middle of a pending write, with commit asserted.
        write(3'd3, 6'h3F, 1'b0);
        rst = 1'b1; commit = 1'b1;
        tick();
        idle_inputs();
        check("midrst_q", q, 24'h0);
        check("midrst_pend", pend, 4'b0000);
`ifdef FDSYNCR_QN_EN
        check("midrst_qn", qn[3*W +: W], 6'h3F);
`endif

        // Randomized phase.
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(63) == 0);
            wr_en   = ($urandom_range(1) == 1);
            wr_ch   = 3'($urandom_range(7));
            wr_data = 6'($urandom);
            commit  = ($urandom_range(3) == 0);
            rd_ch   = 3'($urandom_range(7));
            tick();
        end
        idle_inputs();
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
